// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush/forward/halt controller
//
// Purpose: per-stage enable and bubble control for an NSTAGES-deep in-order
// pipeline. Handles data-memory wait, RAW hazards, instruction-fetch wait,
// branch flush, and a halt drain sequence that ends in a permanent HALTED
// state.
//
// Configuration macro: PIPELINE_FORWARD_EN
//   defined   - fwd_a/fwd_b select memory/writeback bypass; only load-use stalls
//   undefined - no bypass; any pending write to a used source stalls decode
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   ihit, dhit                 fetch / data access complete
//   halt_req, br_taken         halt decoded / branch taken, both in decode
//   dreq_r, dreq_w             load / store present in memory stage
//   de_rs, de_rt, de_use_*     decode source registers and use flags
//   ex_regwen, ex_memren, ex_rd   execute-stage destination info
//   mem_regwen, mem_rd         memory-stage destination info
//   wb_regwen, wb_rd           writeback-stage destination info
//   stage_en, stage_flush      per-stage register enable / bubble insert
//   fwd_a, fwd_b               00 regfile, 01 memory stage, 10 writeback
//   imemREN, dmemREN, dmemWEN  memory requests
//   halt                       processor halted
//   stall_cnt                  saturating count of stalled fetch cycles

module pipeline_ctrl #(
    parameter int NSTAGES = 5,
    parameter int REGW    = 5,
    parameter int CNTW    = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               halt_req,
    input  logic               br_taken,
    input  logic               dreq_r,
    input  logic               dreq_w,
    input  logic [REGW-1:0]    de_rs,
    input  logic [REGW-1:0]    de_rt,
    input  logic               de_use_rs,
    input  logic               de_use_rt,
    input  logic               ex_regwen,
    input  logic               ex_memren,
    input  logic [REGW-1:0]    ex_rd,
    input  logic               mem_regwen,
    input  logic [REGW-1:0]    mem_rd,
    input  logic               wb_regwen,
    input  logic [REGW-1:0]    wb_rd,
    output logic [NSTAGES-1:0] stage_en,
    output logic [NSTAGES-1:0] stage_flush,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               imemREN,
    output logic               dmemREN,
    output logic               dmemWEN,
    output logic               halt,
    output logic [CNTW-1:0]    stall_cnt
);

    typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

    localparam int DCW = $clog2(NSTAGES);

    localparam logic [NSTAGES-1:0] EN_ALL = {NSTAGES{1'b1}};
    // decode and fetch hold; execute onward advances with a bubble in execute
    localparam logic [NSTAGES-1:0] EN_HAZ = {{(NSTAGES-2){1'b1}}, 2'b00};
    // only fetch holds; decode receives a bubble
    localparam logic [NSTAGES-1:0] EN_IF  = {{(NSTAGES-1){1'b1}}, 1'b0};
    localparam logic [NSTAGES-1:0] FL_DEC = NSTAGES'(2);
    localparam logic [NSTAGES-1:0] FL_EX  = NSTAGES'(4);

    state_t          state_q, state_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
    logic load_use, hazard, dstall;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    // Source/destination match terms; rd==0 is the hardwired zero register.
    assign rs_ex  = de_use_rs & (ex_rd != '0) & (de_rs == ex_rd);
    assign rt_ex  = de_use_rt & (ex_rd != '0) & (de_rt == ex_rd);
    assign rs_mem = mem_regwen & (mem_rd != '0) & (de_rs == mem_rd);
    assign rt_mem = mem_regwen & (mem_rd != '0) & (de_rt == mem_rd);
    assign rs_wb  = wb_regwen & (wb_rd != '0) & (de_rs == wb_rd);
    assign rt_wb  = wb_regwen & (wb_rd != '0) & (de_rt == wb_rd);

    assign load_use = ex_memren & (rs_ex | rt_ex);
    assign dstall   = (dreq_r | dreq_w) & ~dhit;

`ifdef PIPELINE_FORWARD_EN
    // A load result is not available until after the memory stage, so only
    // load-use still needs a stall; everything else is bypassed.
    logic unused_fwd;
    assign unused_fwd = ex_regwen;
    assign hazard    = load_use;
    assign fwd_a_sel = rs_mem ? 2'b01 : (rs_wb ? 2'b10 : 2'b00);
    assign fwd_b_sel = rt_mem ? 2'b01 : (rt_wb ? 2'b10 : 2'b00);
`else
    // Without bypass, decode waits until no later stage will write a used source.
    assign hazard    = load_use
                     | (ex_regwen & (rs_ex | rt_ex))
                     | (de_use_rs & (rs_mem | rs_wb))
                     | (de_use_rt & (rt_mem | rt_wb));
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    logic [NSTAGES-1:0] en_c, fl_c;
    logic               imem_c, dren_c, dwen_c, halt_c;

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        stall_cnt_d = stall_cnt_q;
        en_c        = '0;
        fl_c        = '0;
        imem_c      = 1'b0;
        dren_c      = 1'b0;
        dwen_c      = 1'b0;
        halt_c      = 1'b0;

        case (state_q)
            RUN, DWAIT: begin
                imem_c = 1'b1;
                dren_c = dreq_r;
                dwen_c = dreq_w;
                if (dstall) begin
                    state_d = DWAIT;
                end else begin
                    state_d = RUN;
                    if (hazard) begin
                        // branch in decode is not resolved yet; it is re-seen next cycle
                        en_c = EN_HAZ;
                        fl_c = FL_EX;
                    end else if (!ihit) begin
                        en_c = EN_IF;
                        fl_c = FL_DEC;
                    end else begin
                        en_c = EN_ALL;
                        if (br_taken) begin
                            fl_c = FL_DEC;
                        end
                    end
                    // halt only leaves decode when decode actually advances
                    if (halt_req && en_c[1]) begin
                        state_d = DRAIN;
                        drain_d = DCW'(NSTAGES - 2);
                    end
                end
                if (!en_c[0] && (stall_cnt_q != {CNTW{1'b1}})) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // memory stage may still hold a load/store that must complete
                dren_c = dreq_r;
                dwen_c = dreq_w;
                fl_c   = FL_DEC;
                if (!dstall) begin
                    en_c    = EN_IF;
                    drain_d = drain_q - 1'b1;
                    if (drain_q == DCW'(1)) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                halt_c = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Reset overrides the outputs combinationally so nothing leaks out
    // while nRST is low, independent of the clock.
    always_comb begin
        if (!nRST) begin
            stage_en    = '0;
            stage_flush = {NSTAGES{1'b1}};
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
            imemREN     = 1'b0;
            dmemREN     = 1'b0;
            dmemWEN     = 1'b0;
            halt        = 1'b0;
        end else begin
            stage_en    = en_c;
            stage_flush = fl_c;
            fwd_a       = fwd_a_sel;
            fwd_b       = fwd_b_sel;
            imemREN     = imem_c;
            dmemREN     = dren_c;
            dmemWEN     = dwen_c;
            halt        = halt_c;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
